// File: rtl/ch_adv_parser.sv
// ch_adv_parser
//   Walks a heartbeat packet held in byte-wide packet RAM and feeds the known-CH selector.
//   Packet layout (big-endian 16-bit words): [type][count][ID,hops,Q] x count.
//   A valid heartbeat (type 0x0001) gives one hb_reset_o pulse. Each of the first CH_LIMIT
//   entries is then presented on fch_*_o, with a one-cycle en_kch_o strobe per entry.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        one-cycle parse request, accepted only while idle
//   base_addr_i    first byte address of the packet
//   mem_rdata_i    RAM read data, valid the cycle after mem_ren_o
//   mem_ren_o      RAM read enable
//   mem_addr_o     RAM read address (base + offset, wraps modulo MEM_DEPTH)
//   hb_reset_o     one-cycle pulse: clear known-CH table
//   en_kch_o       one-cycle pulse: fch_*_o hold a new entry
//   fch_id_o       CH node ID
//   fch_hops_o     hop count to CH
//   fch_qvalue_o   CH Q-value (Q2.14)
//   busy_o         high from start acceptance until done
//   done_o         one-cycle pulse at end of parse
//   err_o          sticky until next accepted start: bad type or count > CH_LIMIT
//
// Configuration macro
//   CHADV_HOPINC_EN  when defined, fch_hops_o = received hops + 1, saturating at 0xFFFF.
//                    When undefined, received hops are passed through unmodified.

module ch_adv_parser #(
   parameter int unsigned MEM_WIDTH  = 8,
   parameter int unsigned MEM_DEPTH  = 2048,
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned CH_LIMIT   = 8,
   parameter int unsigned KCH_GAP    = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] base_addr_i,
   input  logic [MEM_WIDTH-1:0]         mem_rdata_i,
   output logic                         mem_ren_o,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
   output logic                         hb_reset_o,
   output logic                         en_kch_o,
   output logic [WORD_WIDTH-1:0]        fch_id_o,
   output logic [WORD_WIDTH-1:0]        fch_hops_o,
   output logic [WORD_WIDTH-1:0]        fch_qvalue_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o
);

   localparam int unsigned AW   = $clog2(MEM_DEPTH);
   localparam int unsigned GW   = (KCH_GAP > 1) ? $clog2(KCH_GAP) : 1;
   localparam int unsigned HW   = 2 * WORD_WIDTH;
   localparam int unsigned EW   = 3 * WORD_WIDTH - MEM_WIDTH;
   localparam logic [WORD_WIDTH-1:0] LIMIT    = WORD_WIDTH'(CH_LIMIT);
   localparam logic [WORD_WIDTH-1:0] HB_TYPE  = WORD_WIDTH'(1);
   localparam logic [GW-1:0]         GAP_LAST = GW'(KCH_GAP - 1);

   typedef enum logic [2:0] {
      StIdle, StRdHdr, StCheck, StHbRst, StRdEnt, StEmit, StGap, StDone
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         base_q, base_d;
   logic [AW-1:0]         off_q, off_d;
   logic                  phase_q, phase_d;   // 0: drive read, 1: capture data
   logic [2:0]            byte_q, byte_d;
   logic [HW-1:0]         hdr_q, hdr_d;
   logic [EW-1:0]         ent_q, ent_d;       // entry bytes captured so far
   logic [WORD_WIDTH-1:0] idx_q, idx_d;       // entries emitted
   logic [WORD_WIDTH-1:0] num_q, num_d;       // entries to emit
   logic [GW-1:0]         gap_q, gap_d;
   logic                  err_q, err_d;
   logic [WORD_WIDTH-1:0] id_q, id_d;
   logic [WORD_WIDTH-1:0] hops_q, hops_d;
   logic [WORD_WIDTH-1:0] qv_q, qv_d;

   logic [HW-1:0]          hdr_shift;
   logic [3*WORD_WIDTH-1:0] ent_full;
   logic [WORD_WIDTH-1:0]  hdr_type, hdr_count;
   logic [WORD_WIDTH-1:0]  rx_hops, hops_adj;

   assign hdr_shift = {hdr_q[HW-MEM_WIDTH-1:0], mem_rdata_i};
   assign ent_full  = {ent_q, mem_rdata_i};
   assign hdr_type  = hdr_q[HW-1:WORD_WIDTH];
   assign hdr_count = hdr_q[WORD_WIDTH-1:0];
   assign rx_hops   = ent_full[2*WORD_WIDTH-1:WORD_WIDTH];

`ifdef CHADV_HOPINC_EN
   assign hops_adj = (rx_hops == '1) ? rx_hops : rx_hops + WORD_WIDTH'(1);
`else
   assign hops_adj = rx_hops;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         base_q  <= '0;
         off_q   <= '0;
         phase_q <= 1'b0;
         byte_q  <= '0;
         hdr_q   <= '0;
         ent_q   <= '0;
         idx_q   <= '0;
         num_q   <= '0;
         gap_q   <= '0;
         err_q   <= 1'b0;
         id_q    <= '0;
         hops_q  <= '1;
         qv_q    <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         phase_q <= phase_d;
         byte_q  <= byte_d;
         hdr_q   <= hdr_d;
         ent_q   <= ent_d;
         idx_q   <= idx_d;
         num_q   <= num_d;
         gap_q   <= gap_d;
         err_q   <= err_d;
         id_q    <= id_d;
         hops_q  <= hops_d;
         qv_q    <= qv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      off_d   = off_q;
      phase_d = phase_q;
      byte_d  = byte_q;
      hdr_d   = hdr_q;
      ent_d   = ent_q;
      idx_d   = idx_q;
      num_d   = num_q;
      gap_d   = gap_q;
      err_d   = err_q;
      id_d    = id_q;
      hops_d  = hops_q;
      qv_d    = qv_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               base_d  = base_addr_i;
               off_d   = '0;
               phase_d = 1'b0;
               byte_d  = '0;
               err_d   = 1'b0;
               state_d = StRdHdr;
            end
         end
         StRdHdr: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               hdr_d   = hdr_shift;
               off_d   = off_q + AW'(1);
               if (byte_q == 3'd3) begin
                  byte_d  = '0;
                  state_d = StCheck;
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         StCheck: begin
            if (hdr_type != HB_TYPE) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StHbRst;
            end
         end
         StHbRst: begin
            idx_d = '0;
            if (hdr_count > LIMIT) begin
               err_d = 1'b1;
               num_d = LIMIT;
            end else begin
               num_d = hdr_count;
            end
            state_d = (hdr_count == '0) ? StDone : StRdEnt;
         end
         StRdEnt: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               ent_d   = ent_full[EW-1:0];
               off_d   = off_q + AW'(1);
               if (byte_q == 3'd5) begin
                  // Outputs load on entry to StEmit so they are valid alongside en_kch_o.
                  byte_d  = '0;
                  id_d    = ent_full[3*WORD_WIDTH-1:2*WORD_WIDTH];
                  hops_d  = hops_adj;
                  qv_d    = ent_full[WORD_WIDTH-1:0];
                  idx_d   = idx_q + WORD_WIDTH'(1);
                  state_d = StEmit;
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         StEmit: begin
            gap_d = '0;
            if (KCH_GAP == 0) begin
               state_d = (idx_q == num_q) ? StDone : StRdEnt;
            end else begin
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               state_d = (idx_q == num_q) ? StDone : StRdEnt;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mem_ren_o    = ((state_q == StRdHdr) || (state_q == StRdEnt)) && !phase_q;
   assign mem_addr_o   = mem_ren_o ? (base_q + off_q) : '0;
   assign hb_reset_o   = (state_q == StHbRst);
   assign en_kch_o     = (state_q == StEmit);
   assign busy_o       = (state_q != StIdle) && (state_q != StDone);
   assign done_o       = (state_q == StDone);
   assign err_o        = err_q;
   assign fch_id_o     = id_q;
   assign fch_hops_o   = hops_q;
   assign fch_qvalue_o = qv_q;

endmodule
